// File: rtl/box_draw_scheduler.sv
// box_draw_scheduler: arbitrates box-draw jobs from requesters A and B plus a
// full-screen clear, then walks every pixel of the granted job one per cycle
// straight into the VGA adapter.
//
// Handshake: a request is a level sampled only while IDLE; the matching oGnt*
// pulses for exactly one cycle when the job's inputs are captured, and the
// requester must drop its request on seeing that pulse. oDone pulses for one
// cycle when the last pixel has been presented. Nothing is queued.
module box_draw_scheduler #(
   parameter int X_SCREEN_PIXELS = 160,
   parameter int Y_SCREEN_PIXELS = 120,
   parameter int BOX_SIZE        = 4
) (
   input  logic       iClock,
   input  logic       iResetn,
   input  logic       iClear,
   input  logic       iReqA,
   input  logic       iReqB,
   input  logic [7:0] iAX,
   input  logic [6:0] iAY,
   input  logic [2:0] iAColour,
   input  logic [7:0] iBX,
   input  logic [6:0] iBY,
   input  logic [2:0] iBColour,
   output logic       oGntA,
   output logic       oGntB,
   output logic       oGntClear,
   output logic [7:0] oX,
   output logic [6:0] oY,
   output logic [2:0] oColour,
   output logic       oPlot,
   output logic       oBusy,
   output logic       oDone,
   output logic [1:0] oState
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [8:0] X_LIM      = 9'(X_SCREEN_PIXELS);
   localparam logic [7:0] Y_LIM      = 8'(Y_SCREEN_PIXELS);
   localparam logic [7:0] BOX_X_LAST = 8'(BOX_SIZE - 1);
   localparam logic [6:0] BOX_Y_LAST = 7'(BOX_SIZE - 1);
   localparam logic [7:0] CLR_X_LAST = 8'(X_SCREEN_PIXELS - 1);
   localparam logic [6:0] CLR_Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic       r_ptr_b;      // 1: B was granted last, so A wins the next tie
   logic       r_clr;        // current job is a full-screen clear
   logic [7:0] r_bx;
   logic [6:0] r_by;
   logic [2:0] r_col;
   logic [7:0] r_cx;         // counters of the pixel currently on oX/oY
   logic [6:0] r_cy;
   logic [7:0] r_x;
   logic [6:0] r_y;
   logic [2:0] r_colour;
   logic       r_plot;
   logic       r_gnt_a;
   logic       r_gnt_b;
   logic       r_gnt_clr;

   logic       w_idle;
   logic       w_gnt_clr;
   logic       w_gnt_a;
   logic       w_gnt_b;
   logic       w_grant;
   logic [7:0] w_x_last;
   logic [6:0] w_y_last;
   logic       w_cx_wrap;
   logic       w_last;
   logic       w_step;
   logic [7:0] w_ncx;
   logic [6:0] w_ncy;
   logic [7:0] w_src_bx;
   logic [6:0] w_src_by;
   logic [2:0] w_src_col;
   logic [8:0] w_px;
   logic [7:0] w_py;
   logic       w_vis;

   // Arbitration: clear first, then round-robin between A and B.
   assign w_idle    = (r_state == S_IDLE);
   assign w_gnt_clr = w_idle & iClear;
   assign w_gnt_a   = w_idle & ~iClear & iReqA & (~iReqB | r_ptr_b);
   assign w_gnt_b   = w_idle & ~iClear & iReqB & (~iReqA | ~r_ptr_b);
   assign w_grant   = w_gnt_clr | w_gnt_a | w_gnt_b;

   // Walk limits depend on job type; the last pixel ends the DRAW phase.
   assign w_x_last  = r_clr ? CLR_X_LAST : BOX_X_LAST;
   assign w_y_last  = r_clr ? CLR_Y_LAST : BOX_Y_LAST;
   assign w_cx_wrap = (r_cx == w_x_last);
   assign w_last    = w_cx_wrap & (r_cy == w_y_last);
   assign w_step    = w_grant | ((r_state == S_DRAW) & ~w_last);

   // Next pixel to present: origin on a grant, row-major advance in DRAW.
   assign w_ncx = w_grant ? 8'd0 : (w_cx_wrap ? 8'd0 : r_cx + 8'd1);
   assign w_ncy = w_grant ? 7'd0 : (w_cx_wrap ? r_cy + 7'd1 : r_cy);

   // Base/colour come straight from the winner on a grant, else the captured copy.
   assign w_src_bx  = w_grant ? (w_gnt_clr ? 8'd0 : (w_gnt_a ? iAX : iBX)) : r_bx;
   assign w_src_by  = w_grant ? (w_gnt_clr ? 7'd0 : (w_gnt_a ? iAY : iBY)) : r_by;
   assign w_src_col = w_grant ? (w_gnt_clr ? 3'd0 : (w_gnt_a ? iAColour : iBColour)) : r_col;

   // Unwrapped pixel position; anything off-screen is suppressed but still timed.
   assign w_px  = {1'b0, w_src_bx} + {1'b0, w_ncx};
   assign w_py  = {1'b0, w_src_by} + {1'b0, w_ncy};
   assign w_vis = (w_px < X_LIM) & (w_py < Y_LIM);

   // State register.
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // Next-state logic: DONE always lasts exactly one cycle.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_next_state = S_DRAW;
         S_DRAW:  if (w_last)  w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      oBusy  = (r_state != S_IDLE);
      oDone  = (r_state == S_DONE);
      oState = r_state;
   end

   // Job capture, pointer update, pixel counters and registered pixel outputs.
   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         r_ptr_b   <= 1'b1;
         r_clr     <= 1'b0;
         r_bx      <= 8'd0;
         r_by      <= 7'd0;
         r_col     <= 3'd0;
         r_cx      <= 8'd0;
         r_cy      <= 7'd0;
         r_x       <= 8'd0;
         r_y       <= 7'd0;
         r_colour  <= 3'd0;
         r_plot    <= 1'b0;
         r_gnt_a   <= 1'b0;
         r_gnt_b   <= 1'b0;
         r_gnt_clr <= 1'b0;
      end else begin
         r_gnt_a   <= w_gnt_a;
         r_gnt_b   <= w_gnt_b;
         r_gnt_clr <= w_gnt_clr;
         if (w_grant) begin
            r_clr <= w_gnt_clr;
            r_bx  <= w_src_bx;
            r_by  <= w_src_by;
            r_col <= w_src_col;
         end
         if (w_gnt_a) r_ptr_b <= 1'b0;
         if (w_gnt_b) r_ptr_b <= 1'b1;
         if (w_step) begin
            r_cx     <= w_ncx;
            r_cy     <= w_ncy;
            r_x      <= w_px[7:0];
            r_y      <= w_py[6:0];
            r_colour <= w_src_col;
            r_plot   <= w_vis;
         end else begin
            r_plot   <= 1'b0;
         end
      end
   end

   assign oGntA     = r_gnt_a;
   assign oGntB     = r_gnt_b;
   assign oGntClear = r_gnt_clr;
   assign oX        = r_x;
   assign oY        = r_y;
   assign oColour   = r_colour;
   assign oPlot     = r_plot;

endmodule

// File: tb/tb_box_draw_scheduler.sv
// Bench for box_draw_scheduler: directed jobs push their expected grant, plot
// and done events (with the cycle they must appear in) into a queue; a monitor
// pops and compares each event the DUT presents.
module tb_box_draw_scheduler;

   localparam int W  = 53;
   localparam int XS = 160;
   localparam int YS = 120;
   localparam int BS = 4;
   localparam logic [2:0] K_GA   = 3'd1;
   localparam logic [2:0] K_GB   = 3'd2;
   localparam logic [2:0] K_GC   = 3'd3;
   localparam logic [2:0] K_PLOT = 3'd4;
   localparam logic [2:0] K_DONE = 3'd5;

   logic       clk;
   logic       iResetn;
   logic       iClear, iReqA, iReqB;
   logic [7:0] iAX, iBX;
   logic [6:0] iAY, iBY;
   logic [2:0] iAColour, iBColour;
   logic       oGntA, oGntB, oGntClear;
   logic [7:0] oX;
   logic [6:0] oY;
   logic [2:0] oColour;
   logic       oPlot, oBusy, oDone;
   logic [1:0] oState;

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   logic [W-1:0] exp_q[$];

   box_draw_scheduler dut (
      .iClock(clk), .iResetn(iResetn), .iClear(iClear),
      .iReqA(iReqA), .iReqB(iReqB),
      .iAX(iAX), .iAY(iAY), .iAColour(iAColour),
      .iBX(iBX), .iBY(iBY), .iBColour(iBColour),
      .oGntA(oGntA), .oGntB(oGntB), .oGntClear(oGntClear),
      .oX(oX), .oY(oY), .oColour(oColour), .oPlot(oPlot),
      .oBusy(oBusy), .oDone(oDone), .oState(oState)
   );

   // Clock and cycle counter.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] mk(input int c, input logic [2:0] k,
                                       input logic [7:0] x, input logic [6:0] y,
                                       input logic [2:0] col);
      return {32'(c), k, x, y, col};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic cmp_evt(input logic [W-1:0] act, input string name);
      logic [W-1:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s unexpected event cyc=%0d x=%0d y=%0d col=%0d, none required",
                  name, act[52:21], act[17:10], act[9:3], act[2:0]);
         return;
      end
      e = exp_q.pop_front();
      if (act == e) n_pass++;
      else $display("FAIL %s actual cyc=%0d kind=%0d x=%0d y=%0d col=%0d required cyc=%0d kind=%0d x=%0d y=%0d col=%0d",
                    name, act[52:21], act[20:18], act[17:10], act[9:3], act[2:0],
                    e[52:21], e[20:18], e[17:10], e[9:3], e[2:0]);
   endtask

   // Monitor: every grant, plotted pixel and done is matched against the queue.
   always @(negedge clk) begin
      if (oGntClear) cmp_evt(mk(cyc, K_GC, 8'd0, 7'd0, 3'd0), "gnt_clear");
      if (oGntA)     cmp_evt(mk(cyc, K_GA, 8'd0, 7'd0, 3'd0), "gnt_a");
      if (oGntB)     cmp_evt(mk(cyc, K_GB, 8'd0, 7'd0, 3'd0), "gnt_b");
      if (oPlot)     cmp_evt(mk(cyc, K_PLOT, oX, oY, oColour), "plot");
      if (oDone)     cmp_evt(mk(cyc, K_DONE, 8'd0, 7'd0, 3'd0), "done");
   end

   // Expected events of one job granted in cycle g; pixels from index stop_at
   // onward (and the done) are omitted for a job cut short by reset.
   task automatic expect_job(input logic [2:0] kind, input int g, input int bx,
                             input int by, input int col, input bit clr, input int stop_at);
      int w, h, n;
      w = clr ? XS : BS;
      h = clr ? YS : BS;
      n = 0;
      exp_q.push_back(mk(g, kind, 8'd0, 7'd0, 3'd0));
      for (int j = 0; j < h; j++) begin
         for (int i = 0; i < w; i++) begin
            if (n < stop_at && (bx + i) < XS && (by + j) < YS)
               exp_q.push_back(mk(g + n, K_PLOT, 8'(bx + i), 7'(by + j), 3'(col)));
            n++;
         end
      end
      if (stop_at >= w * h) exp_q.push_back(mk(g + w * h, K_DONE, 8'd0, 7'd0, 3'd0));
   endtask

   // Returns just after the rising edge that makes cyc reach c.
   task automatic wait_cyc(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_a(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      iAX = x; iAY = y; iAColour = c;
   endtask

   task automatic set_b(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      iBX = x; iBY = y; iBColour = c;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"},     32'(oX), 32'd0);
      chk({tag, "_y"},     32'(oY), 32'd0);
      chk({tag, "_col"},   32'(oColour), 32'd0);
      chk({tag, "_plot"},  32'(oPlot), 32'd0);
      chk({tag, "_busy"},  32'(oBusy), 32'd0);
      chk({tag, "_done"},  32'(oDone), 32'd0);
      chk({tag, "_gnta"},  32'(oGntA), 32'd0);
      chk({tag, "_gntb"},  32'(oGntB), 32'd0);
      chk({tag, "_gntc"},  32'(oGntClear), 32'd0);
      chk({tag, "_state"}, 32'(oState), 32'd0);
   endtask

   int k, k2;

   initial begin
      iResetn = 1'b0;
      iClear = 1'b0; iReqA = 1'b0; iReqB = 1'b0;
      set_a(8'd0, 7'd0, 3'd0);
      set_b(8'd0, 7'd0, 3'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      wait_cyc(cyc + 1);
      iResetn = 1'b1;

      // 1: single A box at (10,20) colour 5.
      k = cyc;
      set_a(8'd10, 7'd20, 3'd5);
      iReqA = 1'b1;
      expect_job(K_GA, k + 1, 10, 20, 5, 1'b0, 16);
      wait_cyc(k + 1);
      iReqA = 1'b0;
      set_a(8'd99, 7'd99, 3'd1);
      wait_cyc(k + 17);
      @(negedge clk);
      chk("t1_done_busy", 32'(oBusy), 32'd1);
      chk("t1_done_plot", 32'(oPlot), 32'd0);
      wait_cyc(k + 18);
      @(negedge clk);
      chk("t1_idle_busy", 32'(oBusy), 32'd0);
      chk("t1_hold_x", 32'(oX), 32'd13);
      chk("t1_hold_y", 32'(oY), 32'd23);

      // 2: A and B both held after a reset; grants alternate A,B,A,B 18 apart.
      wait_cyc(cyc + 1);
      iResetn = 1'b0;
      wait_cyc(cyc + 2);
      iResetn = 1'b1;
      k = cyc;
      set_a(8'd30, 7'd40, 3'd3);
      set_b(8'd50, 7'd60, 3'd6);
      iReqA = 1'b1; iReqB = 1'b1;
      expect_job(K_GA, k + 1,  30,  40, 3, 1'b0, 16);
      expect_job(K_GB, k + 19, 50,  60, 6, 1'b0, 16);
      expect_job(K_GA, k + 37, 100, 100, 1, 1'b0, 16);
      expect_job(K_GB, k + 55, 2,   3,  2, 1'b0, 16);
      wait_cyc(k + 1);
      iReqA = 1'b0;
      set_a(8'd100, 7'd100, 3'd1);
      wait_cyc(k + 2);
      iReqA = 1'b1;
      wait_cyc(k + 19);
      iReqB = 1'b0;
      set_b(8'd2, 7'd3, 3'd2);
      wait_cyc(k + 20);
      iReqB = 1'b1;
      wait_cyc(k + 37);
      iReqA = 1'b0;
      wait_cyc(k + 55);
      iReqB = 1'b0;
      wait_cyc(k + 55 + 18);

      // 3: clear beats A and B; afterwards A wins the tie (pointer still on B).
      k = cyc;
      set_a(8'd7, 7'd8, 3'd4);
      set_b(8'd9, 7'd10, 3'd5);
      iClear = 1'b1; iReqA = 1'b1; iReqB = 1'b1;
      expect_job(K_GC, k + 1, 0, 0, 0, 1'b1, XS * YS);
      expect_job(K_GA, k + 1 + 19202, 7, 8, 4, 1'b0, 16);
      expect_job(K_GB, k + 1 + 19220, 9, 10, 5, 1'b0, 16);
      wait_cyc(k + 1);
      iClear = 1'b0;
      wait_cyc(k + 1 + 19202);
      iReqA = 1'b0;
      wait_cyc(k + 1 + 19220);
      iReqB = 1'b0;
      wait_cyc(k + 1 + 19220 + 18);

      // 4: clipped boxes at (158,118) and (200,5).
      k = cyc;
      set_a(8'd158, 7'd118, 3'd7);
      set_b(8'd200, 7'd5, 3'd2);
      iReqA = 1'b1; iReqB = 1'b1;
      expect_job(K_GA, k + 1,  158, 118, 7, 1'b0, 16);
      expect_job(K_GB, k + 19, 200, 5,   2, 1'b0, 16);
      wait_cyc(k + 1);
      iReqA = 1'b0;
      wait_cyc(k + 19);
      iReqB = 1'b0;
      wait_cyc(k + 19 + 18);

      // 5: reset at pixel 8 of a B box, then a fresh B box completes.
      k = cyc;
      set_b(8'd70, 7'd50, 3'd1);
      iReqB = 1'b1;
      expect_job(K_GB, k + 1, 70, 50, 1, 1'b0, 8);
      wait_cyc(k + 1);
      iReqB = 1'b0;
      wait_cyc(k + 9);
      iResetn = 1'b0;
      #1;
      chk_all_zero("midreset");
      wait_cyc(k + 12);
      iResetn = 1'b1;
      k2 = cyc;
      set_b(8'd20, 7'd100, 3'd4);
      iReqB = 1'b1;
      expect_job(K_GB, k2 + 1, 20, 100, 4, 1'b0, 16);
      wait_cyc(k2 + 1);
      iReqB = 1'b0;
      wait_cyc(k2 + 18);

      // 6: B raised during an A box waits for IDLE; granted in cycle 19.
      k = cyc;
      set_a(8'd40, 7'd60, 3'd6);
      iReqA = 1'b1;
      expect_job(K_GA, k + 1, 40, 60, 6, 1'b0, 16);
      expect_job(K_GB, k + 19, 80, 80, 3, 1'b0, 16);
      wait_cyc(k + 1);
      iReqA = 1'b0;
      wait_cyc(k + 5);
      set_b(8'd80, 7'd80, 3'd3);
      iReqB = 1'b1;
      wait_cyc(k + 19);
      iReqB = 1'b0;
      wait_cyc(k + 19 + 20);

      @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/box_draw_scheduler.md
# box_draw_scheduler

Sequencer and arbiter for the VGA pixel-plot path. It accepts box-draw jobs from two independent requesters (A, B) and a full-screen clear request, and grants one job at a time. For the granted job it walks every pixel, driving oX/oY/oColour/oPlot straight into the VGA adapter. It pulses oDone when the job completes.

## Interface
- X_SCREEN_PIXELS, 160: horizontal resolution; pixels with x ≥ this are clipped.
- Y_SCREEN_PIXELS, 120: vertical resolution; pixels with y ≥ this are clipped.
- BOX_SIZE, 4: box edge length in pixels, power of two, 2..16.

- iClock  in  1  single system clock; all state on the rising edge.
- iResetn  in  1  asynchronous, active-low reset.
- iClear  in  1  level request: clear the whole screen to colour 0.
- iReqA / iReqB  in  1  level request from requester A / B.
- iAX / iBX  in  8  box top-left x.
- iAY / iBY  in  7  box top-left y.
- iAColour / iBColour  in  3  box colour.
- oGntA / oGntB / oGntClear  out  1  one-cycle pulse: the job was accepted and its inputs captured.
- oX  out  8  pixel x, registered.
- oY  out  7  pixel y, registered.
- oColour  out  3  pixel colour, registered.
- oPlot  out  1  pixel write enable.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse at job completion.

## Operation
- States:
  - IDLE: arbitrate.
  - DRAW: one pixel per cycle.
  - DONE: oDone=1 for one cycle, then IDLE unconditionally.
- Arbitration is evaluated only in IDLE, on the sampled request levels:
  - iClear has strict priority.
  - A and B are round-robin. A pointer holds the last granted requester; reset value is B, so A wins the first tie.
  - A clear grant does not move the pointer.
- On the grant edge:
  - Capture base x/y/colour; a clear uses base (0,0) and colour 0.
  - Clear the counters cx, cy.
  - Enter DRAW.
- DRAW pixel order:
  - Row-major: cx increments each cycle; at its limit (BOX_SIZE−1, or X_SCREEN_PIXELS−1 for a clear) it wraps to 0 and cy increments.
  - Leave DRAW after the pixel where cx and cy are both at their limits.
- Pixel arithmetic:
  - x = base_x + cx and y = base_y + cy, computed 9/8 bits wide with no wrap.
  - oPlot=0 for a pixel if x ≥ X_SCREEN_PIXELS or y ≥ Y_SCREEN_PIXELS (clipped).
  - Clipped pixels still consume their cycle, and oX/oY still present the truncated low bits.
- Job length:
  - Box: BOX_SIZE² DRAW cycles.
  - Clear: X_SCREEN_PIXELS × Y_SCREEN_PIXELS DRAW cycles (19200 at defaults).
- Requests arriving outside IDLE are ignored until IDLE; none are queued internally.
- A request still high when IDLE is re-entered is granted again. Requesters must drop their request on seeing the grant.
- Input coordinates and colour may change freely after the grant; only the captured copies are used.

## Timing
- Reset (asynchronous, immediate):
  - All outputs go to 0: oX, oY, oColour, oPlot, oBusy, oDone, and all grants.
  - State returns to IDLE and the pointer to B.
  - A job in progress is abandoned with no oDone.
  - After release, the first rising edge with a request present is a normal arbitration edge.
- Edge E0: IDLE samples a request. In the cycle after E0:
  - The matching oGnt* is high.
  - oBusy=1.
  - The first pixel (cx=cy=0) is on oX/oY/oColour.
  - oPlot reflects the clip result for that pixel.
- Pixel n of the job (n counted from 0) is presented in cycle n+1 after E0.
- Box job at defaults:
  - Cycles 1..16: DRAW.
  - Cycle 17: DONE, oDone=1, oPlot=0, oBusy=1.
  - Cycle 18: IDLE, oBusy=0.
  - The earliest next grant pulse is cycle 19, so box throughput is 18 cycles.
- Clear job: 19200 DRAW cycles plus 1 DONE cycle.
- oX, oY and oColour hold their last value in DONE and IDLE.
- oGnt*, oPlot and oDone are never high simultaneously outside DRAW/DONE as stated above. In particular, oGnt* and oDone are never high in the same cycle.

## Test plan
1. Reset, then iReqA=1 with (10,20), colour 5 → oGntA pulses once. 16 plots with colour 5: (10,20),(11,20)…(13,20),(10,21)…(13,23). oDone in cycle 17, oBusy low in cycle 18.
2. iReqA and iReqB both held, each dropped for one cycle after its grant and then re-raised → grants alternate A,B,A,B. Each job has 16 plots and one oDone; grants are 18 cycles apart.
3. iClear and iReqA raised together → oGntClear first. 19200 plots, colour 0, first (0,0), last (159,119), then oDone. Next comes oGntA, with the round-robin pointer unchanged.
4. Box at (158,118) → 16 DRAW cycles but only 4 with oPlot=1: (158,118),(159,118),(158,119),(159,119). Box at (200,5) → zero plots, oDone still pulses.
5. iResetn driven low asynchronously mid-box, at pixel 8 → all outputs 0 before the next edge and no oDone. After release, a new iReqB is granted normally and completes all 16 pixels.
6. iReqB asserted during an A job → ignored until IDLE. oGntB arrives in cycle 19 relative to A's grant edge.
